// File: rtl/or1200_vlx_packer.sv
// or1200_vlx_packer: MSB-first VLC bit packer with 0xFF byte stuffing, byte FIFO and byte-store drain port.
// Flush pads the accumulator with 1s to a byte boundary and holds the CPU until everything has been stored.
module or1200_vlx_packer #(
  parameter int MAX_LEN = 16,
  parameter int ACC_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit STUFF_EN = 1'b1,
  parameter logic [31:0] ADDR_RESET = 32'h0,
  localparam int NB_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               set_bit_op_i,
  input  logic [MAX_LEN-1:0] dat_i,
  input  logic [NB_W-1:0]    num_bits_i,
  input  logic               flush_i,
  input  logic               spr_cs_i,
  input  logic               spr_write_i,
  input  logic [1:0]         spr_addr_i,
  input  logic [31:0]        spr_dat_i,
  output logic [31:0]        spr_dat_o,
  output logic               stall_cpu_o,
  output logic               store_req_o,
  output logic [31:0]        store_addr_o,
  output logic [7:0]         store_dat_o,
  input  logic               store_ack_i
);
  localparam int CW = $clog2(ACC_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PAD, DRAIN, DONE} state_t;

  state_t state, state_nx;
  logic [ACC_W-1:0] acc, ins;
  logic [CW-1:0] cnt, sh;
  logic [NB_W-1:0] n;
  logic [MAX_LEN-1:0] code;
  logic [2:0] p;
  logic [7:0] ext_byte, push_dat;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, level;
  logic [31:0] addr, bytecnt;
  logic space_ok, accept, ext, push, pop, full, fifo_space, pend_zero, wr_addr, wr_cnt;

  assign n = (num_bits_i > NB_W'(MAX_LEN)) ? NB_W'(MAX_LEN) : num_bits_i;
  assign code = dat_i & ~({MAX_LEN{1'b1}} << n);
  assign space_ok = (CW'(ACC_W) - cnt) >= CW'(n);
  assign accept = set_bit_op_i & space_ok & (state == IDLE || state == DONE);
  assign p = 3'(4'd8 - {1'b0, cnt[2:0]});
  // Code insertion and flush padding share one shifter; the byte extracted in the same cycle is read pre-shift.
  assign sh = accept ? CW'(n) : (state == PAD) ? CW'(p) : '0;
  assign ins = accept ? ACC_W'(code) : (state == PAD) ? ACC_W'((9'd1 << p) - 9'd1) : '0;

  assign level = wp - rp;
  assign full = level == (AW + 1)'(FIFO_DEPTH);
  assign pop = store_req_o & store_ack_i;
  assign fifo_space = ~full | pop;
  assign ext = (cnt >= CW'(8)) & ~pend_zero & fifo_space;
  assign ext_byte = 8'(acc >> (cnt - CW'(8)));
  assign push = ext | (pend_zero & fifo_space);
  assign push_dat = pend_zero ? 8'h00 : ext_byte;

  assign wr_addr = spr_cs_i & spr_write_i & (spr_addr_i == 2'd0);
  assign wr_cnt = spr_cs_i & spr_write_i & (spr_addr_i == 2'd1);

  assign store_req_o = wp != rp;
  assign store_addr_o = addr;
  assign store_dat_o = mem[rp[AW-1:0]];
  assign stall_cpu_o = (set_bit_op_i & ~space_ok) | (flush_i & (state != DONE)) | (state == PAD) | (state == DRAIN);
  assign spr_dat_o = (spr_addr_i == 2'd0) ? addr :
                     (spr_addr_i == 2'd1) ? bytecnt :
                     (spr_addr_i == 2'd2) ? {16'b0, 8'(level), 1'b0, pend_zero, 6'(cnt)} : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (flush_i & ~set_bit_op_i) ? PAD : IDLE;
      PAD:     state_nx = DRAIN;
      DRAIN:   state_nx = (cnt == '0 && !pend_zero && !store_req_o) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      pend_zero <= 1'b0;
      addr <= ADDR_RESET;
      bytecnt <= '0;
    end else if (wr_addr) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      pend_zero <= 1'b0;
      addr <= spr_dat_i;
      bytecnt <= '0;
    end else begin
      state <= state_nx;
      acc <= (acc << sh) | ins;
      cnt <= cnt + sh - (ext ? CW'(8) : '0);
      if (push) wp <= wp + (AW + 1)'(1);
      if (pop) begin
        rp <= rp + (AW + 1)'(1);
        addr <= addr + 32'd1;
      end
      bytecnt <= wr_cnt ? '0 : bytecnt + 32'(pop);
      pend_zero <= pend_zero ? ~fifo_space : (ext & STUFF_EN & (ext_byte == 8'hFF));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push & ~wr_addr) mem[wp[AW-1:0]] <= push_dat;
  end
endmodule
